player_motion: RTL
==================

// Module: player_motion
// PURPOSE
//   Per-frame player car state: turns keyboard keycodes into PlayerX/PlayerY for the
//   player sprite plotter, plus a forward speed for road scrolling. Handles crashes:
//   freezes the car, then steers it back to the start lane. Sits directly upstream of
//   the player plot stage; its collision input comes from the pixel-priority logic.
// PARAMETERS
//   X_MIN        10'd160  left road edge (leftmost legal PlayerX)
//   X_MAX        10'd480  right road edge (PlayerX + CAR_W must stay <= X_MAX)
//   CAR_W        10'd47   car sprite width
//   X_START      10'd296  reset/recovery lane X
//   Y_START      10'd400  PlayerY at speed 0
//   STEP         10'd2    lateral pixels per frame
//   MAX_SPEED    4'd15    speed saturation value
//   CRASH_FRAMES 6'd60    frames held in CRASH
// PORTS
//   clk        in   1   system clock (50 MHz)
//   Reset      in   1   asynchronous, active-high reset
//   frame_clk  in   1   VGA vsync-derived frame clock, async to clk
//   keycode    in   8   USB HID keycode; 0x00 = no key
//   collision  in   1   player pixel overlaps obstacle pixel (level, clk domain)
//   PlayerX    out  10  sprite top-left X
//   PlayerY    out  10  sprite top-left Y
//   speed      out  4   forward speed, 0..MAX_SPEED
//   crashed    out  1   high in CRASH and RECOVER
// BEHAVIOUR
//   Reset (async): PlayerX=X_START, PlayerY=Y_START, speed=0, crashed=0, state=DRIVE,
//     crash counter=0, decay counter=0, synchroniser flops=0.
//   frame_clk: 2-flop synchroniser + rising-edge detect -> tick, one clk wide.
//     All state updates happen on the clk edge where tick=1 (except crash entry).
//   Keys: 0x04 A=left, 0x07 D=right, 0x1A W=accelerate, 0x16 S=brake; others = none.
//   DRIVE, on tick:
//     A: PlayerX = max(PlayerX-STEP, X_MIN); D: PlayerX = min(PlayerX+STEP, X_MAX-CAR_W).
//     Compare in 11-bit arithmetic; no wrap below 0 or above 1023.
//     W: speed+1, saturate at MAX_SPEED; S: speed-1, saturate at 0; decay counter cleared.
//     Other key/none: 2-bit decay counter increments; when it wraps 3->0, speed-1 (sat 0).
//     PlayerY = Y_START - 2*speed (new speed), registered same edge.
//   DRIVE, collision=1 on any clk edge: -> CRASH; speed=0, PlayerY=Y_START, crashed=1,
//     crash counter=CRASH_FRAMES. If tick coincides, crash wins: no key update.
//   CRASH: keys and collision ignored; each tick decrements counter; tick with
//     counter==1 -> RECOVER (counter reaches 0).
//   RECOVER, on tick: PlayerX moves toward X_START by STEP; if |PlayerX-X_START|<=STEP,
//     snap to X_START and -> DRIVE with crashed=0 on that edge. Keys and collision ignored.
//   Outputs are registered; PlayerX/Y/speed change only on tick edges or crash entry.
//   Reset mid-crash returns immediately to reset values and DRIVE.
// TESTING
//   1 Reset, keycode=0x07, 200 ticks -> PlayerX climbs by 2/tick, stops at 433 (480-47).
//   2 keycode=0x04 from X=161 -> next tick X=160, stays 160; never wraps to 1023.
//   3 W held 20 ticks -> speed 15 saturates, PlayerY=370; release: speed 14 after 4 ticks.
//   4 collision pulse (1 clk) at X=200, speed 8, same cycle as tick -> crashed=1, speed 0,
//     X stays 200; after 60 ticks RECOVER; X reaches 296 in 48 ticks, crashed drops.
//   5 Keys and collision during CRASH/RECOVER -> no effect on X, speed, or timing.
//   6 Reset asserted mid-RECOVER without clk -> outputs at reset values immediately.

Source files
------------

// File: rtl/player_motion_if.sv
// Bundle of the player-motion signals shared between the car-state block and
// whatever drives it (keyboard/collision sources) and consumes it (sprite plotter,
// road scroller).
//   frame_clk  : vsync-derived frame clock, asynchronous to the system clock
//   keycode    : USB HID keycode, 0x00 = no key
//   collision  : player pixel overlaps an obstacle pixel (level, clk domain)
//   PlayerX/Y  : sprite top-left position
//   speed      : forward speed, 0..15
//   crashed    : high while the car is frozen or being steered back
interface player_motion_if;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       collision;
  logic [9:0] PlayerX;
  logic [9:0] PlayerY;
  logic [3:0] speed;
  logic       crashed;

  // Stimulus side: drives frame clock, keys and collision, observes the car state.
  modport master (
    output frame_clk, keycode, collision,
    input  PlayerX, PlayerY, speed, crashed
  );

  // Car-state block side.
  modport slave (
    input  frame_clk, keycode, collision,
    output PlayerX, PlayerY, speed, crashed
  );
endinterface

// File: rtl/player_motion.sv
// Per-frame player car state. Converts keycodes into the sprite position and a
// forward speed, once per frame tick. A collision freezes the car for a fixed
// number of frames, after which it is steered back to the start lane before
// keyboard control resumes.
// Ports:
//   clk     : system clock
//   Reset   : asynchronous, active-high reset
//   mot_io  : player_motion_if.slave (frame_clk, keycode, collision in;
//             PlayerX, PlayerY, speed, crashed out, all registered)
module player_motion #(
  parameter logic [9:0] XMin        = 10'd160,
  parameter logic [9:0] XMax        = 10'd480,
  parameter logic [9:0] CarW        = 10'd47,
  parameter logic [9:0] XStart      = 10'd296,
  parameter logic [9:0] YStart      = 10'd400,
  parameter logic [9:0] Step        = 10'd2,
  parameter logic [3:0] MaxSpeed    = 4'd15,
  parameter logic [5:0] CrashFrames = 6'd60
) (
  input logic             clk,
  input logic             Reset,
  player_motion_if.slave  mot_io
);

  localparam logic [7:0] KeyA = 8'h04;
  localparam logic [7:0] KeyD = 8'h07;
  localparam logic [7:0] KeyW = 8'h1A;
  localparam logic [7:0] KeyS = 8'h16;

  // Bounds widened to 11 bits so the step arithmetic can never wrap.
  localparam logic [10:0] XLeftLim  = {1'b0, XMin} + {1'b0, Step};
  localparam logic [10:0] XRightMax = {1'b0, XMax} - {1'b0, CarW};

  typedef enum logic [1:0] {StDrive, StCrash, StRecover} state_e;

  state_e      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [3:0]  speed_q, speed_d;
  logic        crashed_q, crashed_d;
  logic [5:0]  crash_cnt_q, crash_cnt_d;
  logic [1:0]  decay_q, decay_d;

  // frame_clk synchroniser and rising-edge detector.
  logic fclk_meta_q, fclk_sync_q, fclk_prev_q;
  logic tick;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      fclk_meta_q <= 1'b0;
      fclk_sync_q <= 1'b0;
      fclk_prev_q <= 1'b0;
    end else begin
      fclk_meta_q <= mot_io.frame_clk;
      fclk_sync_q <= fclk_meta_q;
      fclk_prev_q <= fclk_sync_q;
    end
  end

  assign tick = fclk_sync_q & ~fclk_prev_q;

  // Candidate lateral moves, clamped to the road edges.
  logic [10:0] x_ext;
  logic [9:0]  x_left, x_right;

  always_comb begin
    x_ext   = {1'b0, x_q};
    x_left  = (x_ext >= XLeftLim) ? (x_q - Step) : XMin;
    x_right = ((x_ext + {1'b0, Step}) >= XRightMax) ? XRightMax[9:0] : (x_q + Step);
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    speed_d     = speed_q;
    crashed_d   = crashed_q;
    crash_cnt_d = crash_cnt_q;
    decay_d     = decay_q;

    unique case (state_q)
      StDrive: begin
        // Collision is checked on every clk edge and overrides a coincident tick.
        if (mot_io.collision) begin
          state_d     = StCrash;
          speed_d     = 4'd0;
          y_d         = YStart;
          crashed_d   = 1'b1;
          crash_cnt_d = CrashFrames;
        end else if (tick) begin
          case (mot_io.keycode)
            KeyA: x_d = x_left;
            KeyD: x_d = x_right;
            KeyW: begin
              speed_d = (speed_q >= MaxSpeed) ? MaxSpeed : (speed_q + 4'd1);
              decay_d = 2'd0;
            end
            KeyS: begin
              speed_d = (speed_q == 4'd0) ? 4'd0 : (speed_q - 4'd1);
              decay_d = 2'd0;
            end
            default: begin
              // Coasting: lose one unit of speed every fourth frame.
              decay_d = decay_q + 2'd1;
              if ((decay_q == 2'd3) && (speed_q != 4'd0)) begin
                speed_d = speed_q - 4'd1;
              end
            end
          endcase
          y_d = YStart - {5'd0, speed_d, 1'b0};
        end
      end

      StCrash: begin
        if (tick) begin
          crash_cnt_d = crash_cnt_q - 6'd1;
          if (crash_cnt_q == 6'd1) begin
            state_d = StRecover;
          end
        end
      end

      StRecover: begin
        if (tick) begin
          if (x_q >= XStart) begin
            if ((x_q - XStart) <= Step) begin
              x_d       = XStart;
              state_d   = StDrive;
              crashed_d = 1'b0;
            end else begin
              x_d = x_q - Step;
            end
          end else begin
            if ((XStart - x_q) <= Step) begin
              x_d       = XStart;
              state_d   = StDrive;
              crashed_d = 1'b0;
            end else begin
              x_d = x_q + Step;
            end
          end
        end
      end

      default: state_d = StDrive;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StDrive;
      x_q         <= XStart;
      y_q         <= YStart;
      speed_q     <= 4'd0;
      crashed_q   <= 1'b0;
      crash_cnt_q <= 6'd0;
      decay_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      speed_q     <= speed_d;
      crashed_q   <= crashed_d;
      crash_cnt_q <= crash_cnt_d;
      decay_q     <= decay_d;
    end
  end

  assign mot_io.PlayerX = x_q;
  assign mot_io.PlayerY = y_q;
  assign mot_io.speed   = speed_q;
  assign mot_io.crashed = crashed_q;

endmodule
